phase_accum_scheduler: RTL and testbench
========================================

PHASE_ACCUM_SCHEDULER -- requirements
Module: phase_accum_scheduler

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 32, which sets the frequency-error sample width (signed).
REQ-002 SHALL have parameter ACCUMULATOR_WIDTH, default 32, which sets the phase accumulator width (signed; full scale = 2*pi).
REQ-003 SHALL have parameter N_CH, default 4, which sets the number of requester channels (2..16).
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port s_tdata, input, N_CH*INPUT_WIDTH bits: per-channel frequency error; channel i occupies bits [i*INPUT_WIDTH +: INPUT_WIDTH].
REQ-007 SHALL have ports s_tvalid (input) and s_tready (output), N_CH bits each: per-channel AXI-Stream handshake.
REQ-008 SHALL have port clr, input, N_CH bits: a pulse on bit i zeroes the accumulator of channel i.
REQ-009 SHALL have port m_tdata, output, ACCUMULATOR_WIDTH bits: the updated phase.
REQ-010 SHALL have port m_tuser, output, $clog2(N_CH) bits: the channel ID of m_tdata.
REQ-011 SHALL have ports m_tvalid (output) and m_tready (input), 1 bit each: output handshake.

Function
REQ-012 SHALL use one shared adder, time-multiplexed over N_CH accumulator registers.
REQ-013 SHALL use an FSM with states IDLE (output register empty) and HOLD (m_tvalid=1).
- IDLE->HOLD on accept.
- HOLD->IDLE on m_tready with no new accept.
- HOLD stays in HOLD on m_tready together with an accept.
REQ-014 SHALL let the module accept in a cycle (can_accept) only in IDLE, or in HOLD with m_tready=1.
REQ-015 SHALL grant by round-robin among the asserted s_tvalid bits, searching from (last granted+1) mod N_CH, with at most one grant per cycle.
REQ-016 SHALL assert s_tready[i] only for the granted channel, and only when can_accept=1; s_tready SHALL be combinational from s_tvalid, the pointer, the FSM state and m_tready.
REQ-017 SHALL, on accept of channel i, compute acc[i] <= acc[i] + sign-extended s_tdata[i], with the sum wrapping modulo 2^ACCUMULATOR_WIDTH.
REQ-018 SHALL, in the same edge as REQ-017, load m_tdata with the new acc[i], load m_tuser with i, and set m_tvalid=1; latency is 1 cycle.
REQ-019 SHALL hold m_tdata and m_tuser stable while m_tvalid=1 and m_tready=0.
REQ-020 SHALL zero acc[i] on clr[i] when there is no accept on channel i.
REQ-021 SHALL, on clr[i] in the same cycle as an accept on channel i, apply the clear first, so the result equals sign-extended s_tdata[i].
REQ-022 SHALL leave the round-robin pointer unchanged in cycles with no accept.

Reset
REQ-023 SHALL, while rst is high, force all acc[i]=0, m_tvalid=0, m_tdata=0, m_tuser=0, pointer=0 and state=IDLE.
REQ-024 SHALL hold s_tready at 0 while rst is high.
REQ-025 SHALL discard any held output when reset is asserted mid-operation.

Configuration
REQ-026 SHALL, when macro PHASE_WRAP_COUNT_EN is defined, add output m_twrap, 16 bits signed, holding a per-channel cycle-slip count:
- +1 on positive overflow of the REQ-017 add;
- -1 on negative overflow;
- the count itself wraps modulo 2^16;
- clr[i] zeroes it;
- reset value 0;
- m_twrap is registered alongside m_tdata.
REQ-027 SHALL, without PHASE_WRAP_COUNT_EN, have neither the port nor the wrap-count logic.

Structure
REQ-028 SHALL place the default widths, the N_CH limits, the channel-ID typedef and the FSM state enum in package phase_sched_pkg.
REQ-029 SHALL implement the round-robin grant (REQ-015, REQ-022) in sub-module rr_arbiter (inputs: request vector, advance; outputs: one-hot grant, grant index).

Verification
REQ-030 SHALL verify single channel:
- Stimulus: ch0 sends 0x10000000 four times, m_tready=1.
- Response: m_tdata = 0x10000000, 0x20000000, 0x30000000, 0x40000000; m_tuser=0; each result 1 cycle after its accept.
REQ-031 SHALL verify fairness:
- Stimulus: all 4 channels hold s_tvalid=1 with data=channel+1.
- Response: m_tuser sequence 0,1,2,3,0,1,...; after 8 outputs acc = {2,4,6,8}.
REQ-032 SHALL verify backpressure:
- Stimulus: m_tready=0 for 5 cycles after the first accept.
- Response: s_tready all 0; m_tdata/m_tuser stable; no sample lost after m_tready returns to 1.
REQ-033 SHALL verify wrap:
- Stimulus: ch1 acc=0x7FFFFFF0, add 0x20.
- Response: m_tdata=0x80000010; with PHASE_WRAP_COUNT_EN, m_twrap=+1.
- Then add 0xFFFFFFE0 (-0x20): m_tdata=0x7FFFFFF0 and m_twrap=0.
REQ-034 SHALL verify clear collision:
- Stimulus: ch2 acc=0x1234, then clr[2] in the same cycle as an accept of 0x5.
- Response: m_tdata=0x5.
REQ-035 SHALL verify reset mid-HOLD:
- Stimulus: assert rst while m_tvalid=1.
- Response: m_tvalid=0 immediately, all accumulators 0, and first grant after release goes to ch0.

Source files
------------

// File: rtl/phase_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_sched_pkg
// Description : Shared defaults, channel-count limits, channel-ID type and
//               FSM state encoding for the phase accumulator scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package phase_sched_pkg;

  localparam int DEF_INPUT_WIDTH       = 32;
  localparam int DEF_ACCUMULATOR_WIDTH = 32;
  localparam int DEF_N_CH              = 4;
  localparam int N_CH_MIN              = 2;
  localparam int N_CH_MAX              = 16;

  // Wide enough for the largest supported channel count
  typedef logic [$clog2(N_CH_MAX)-1:0] ch_id_t;

  // IDLE: output register empty, HOLD: output register holds a result
  typedef enum logic [0:0] {
    SCHED_IDLE = 1'b0,
    SCHED_HOLD = 1'b1
  } sched_state_e;

endpackage : phase_sched_pkg
`default_nettype wire

// File: rtl/phase_accum_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Searches the request vector starting at
//               the channel after the last one granted and produces a one-hot
//               grant plus its index. The pointer only moves on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import phase_sched_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  ch_id_t ptr_q;
  ch_id_t ptr_d;
  int     cand;
  logic   found;

  // First asserted request at or after the pointer, wrapping around
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N_CH; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Pointer moves to the channel after the granted one only when a grant is taken
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(grant_idx) == N_CH - 1) ? '0 : ch_id_t'(int'(grant_idx) + 1);
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/phase_accum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : phase_accum_scheduler
// Description : N_CH phase accumulators sharing one adder. Channels are
//               served round-robin over per-channel AXI-Stream inputs; each
//               accepted sample updates its accumulator and the new phase is
//               presented on a registered output one cycle later.
//               Optional: define PHASE_WRAP_COUNT_EN to add m_twrap, a signed
//               per-channel cycle-slip counter registered with m_tdata.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_accum_scheduler
  import phase_sched_pkg::*;
#(
  parameter  int INPUT_WIDTH       = DEF_INPUT_WIDTH,
  parameter  int ACCUMULATOR_WIDTH = DEF_ACCUMULATOR_WIDTH,
  parameter  int N_CH              = DEF_N_CH,
  localparam int ID_W              = $clog2(N_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH*INPUT_WIDTH-1:0]   s_tdata,
  input  logic [N_CH-1:0]               s_tvalid,
  output logic [N_CH-1:0]               s_tready,
  input  logic [N_CH-1:0]               clr,
  output logic [ACCUMULATOR_WIDTH-1:0]  m_tdata,
  output logic [ID_W-1:0]               m_tuser,
`ifdef PHASE_WRAP_COUNT_EN
  output logic signed [15:0]            m_twrap,
`endif
  output logic                          m_tvalid,
  input  logic                          m_tready
);

  localparam int AW = ACCUMULATOR_WIDTH;
  localparam logic [0:0] ST_IDLE = SCHED_IDLE;
  localparam logic [0:0] ST_HOLD = SCHED_HOLD;

  logic [0:0]       state_q, state_d;
  logic [N_CH-1:0]  grant;
  logic [ID_W-1:0]  grant_idx;
  logic             can_accept;
  logic             accept;

  logic [AW-1:0]    acc_q [N_CH];
  logic [AW-1:0]    acc_d [N_CH];
  logic [INPUT_WIDTH-1:0] sel_data;
  logic [AW-1:0]    add_a, add_b, add_sum;

  logic [AW-1:0]    m_tdata_q, m_tdata_d;
  logic [ID_W-1:0]  m_tuser_q, m_tuser_d;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (s_tvalid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Handshake: only the granted channel sees ready, and only when the output can take a result
  always_comb begin
    can_accept = (state_q == ST_IDLE) || m_tready;
    s_tready   = grant & {N_CH{can_accept & ~rst}};
    accept     = |(s_tvalid & s_tready);
  end

  // Shared adder: granted accumulator (cleared first on a colliding clr) plus sign-extended sample
  always_comb begin
    sel_data = s_tdata[int'(grant_idx)*INPUT_WIDTH +: INPUT_WIDTH];
    add_a    = clr[grant_idx] ? '0 : acc_q[grant_idx];
    add_b    = AW'($signed(sel_data));
    add_sum  = add_a + add_b;
  end

  // Per-channel accumulator next state: accept wins, otherwise clr zeroes
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      acc_d[i] = acc_q[i];
      if (accept && (int'(grant_idx) == i)) acc_d[i] = add_sum;
      else if (clr[i])                      acc_d[i] = '0;
    end
  end

  // Output register and FSM: load on accept, drain on m_tready otherwise
  always_comb begin
    state_d   = state_q;
    m_tdata_d = m_tdata_q;
    m_tuser_d = m_tuser_q;
    if (accept) begin
      state_d   = ST_HOLD;
      m_tdata_d = add_sum;
      m_tuser_d = grant_idx;
    end else if ((state_q == ST_HOLD) && m_tready) begin
      state_d   = ST_IDLE;
    end
  end

  // Accumulator, output and state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_tdata_q <= '0;
      m_tuser_q <= '0;
      for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      m_tdata_q <= m_tdata_d;
      m_tuser_q <= m_tuser_d;
      for (int i = 0; i < N_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tuser  = m_tuser_q;
  assign m_tvalid = (state_q == ST_HOLD);

`ifdef PHASE_WRAP_COUNT_EN
  logic          ovf_pos, ovf_neg;
  logic [15:0]   wrap_q [N_CH];
  logic [15:0]   wrap_d [N_CH];
  logic [15:0]   wrap_new;
  logic [15:0]   m_twrap_q, m_twrap_d;

  // Signed overflow of the shared add gives the slip direction
  always_comb begin
    ovf_pos  = ~add_a[AW-1] & ~add_b[AW-1] &  add_sum[AW-1];
    ovf_neg  =  add_a[AW-1] &  add_b[AW-1] & ~add_sum[AW-1];
    wrap_new = (clr[grant_idx] ? 16'd0 : wrap_q[grant_idx])
               + (ovf_pos ? 16'd1 : 16'd0) - (ovf_neg ? 16'd1 : 16'd0);
    for (int i = 0; i < N_CH; i++) begin
      wrap_d[i] = wrap_q[i];
      if (accept && (int'(grant_idx) == i)) wrap_d[i] = wrap_new;
      else if (clr[i])                      wrap_d[i] = '0;
    end
    m_twrap_d = accept ? wrap_new : m_twrap_q;
  end

  // Slip counters and their output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_twrap_q <= '0;
      for (int i = 0; i < N_CH; i++) wrap_q[i] <= '0;
    end else begin
      m_twrap_q <= m_twrap_d;
      for (int i = 0; i < N_CH; i++) wrap_q[i] <= wrap_d[i];
    end
  end

  assign m_twrap = m_twrap_q;
`endif

endmodule : phase_accum_scheduler
`default_nettype wire

// File: tb/tb_phase_accum_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_accum_scheduler
// Description : Self-checking bench for phase_accum_scheduler with a
//               behavioural reference model (round-robin search, wrapping
//               accumulation, output hold) and directed plus random steps.
//               Honours PHASE_WRAP_COUNT_EN for the m_twrap checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_accum_scheduler;

  localparam int N  = 4;
  localparam int IW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*IW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    clr;
  logic [AW-1:0]   m_tdata;
  logic [1:0]      m_tuser;
  logic            m_tvalid;
  logic            m_tready;
`ifdef PHASE_WRAP_COUNT_EN
  logic [15:0]     m_twrap;
`endif

  phase_accum_scheduler #(
    .INPUT_WIDTH       (IW),
    .ACCUMULATOR_WIDTH (AW),
    .N_CH              (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .clr      (clr),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tuser),
`ifdef PHASE_WRAP_COUNT_EN
    .m_twrap  (m_twrap),
`endif
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus for the next step
  logic [N-1:0]  tb_valid;
  logic [N-1:0]  tb_clr;
  logic          tb_mready;
  logic [31:0]   tb_data [N];

  // Reference model
  logic [31:0]   mdl_acc  [N];
  logic [15:0]   mdl_wrap [N];
  int            mdl_ptr;
  logic          mdl_valid;
  logic [31:0]   mdl_data;
  logic [1:0]    mdl_user;
  logic [15:0]   mdl_twrap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mdl_acc[i]  = '0;
      mdl_wrap[i] = '0;
    end
    mdl_ptr   = 0;
    mdl_valid = 1'b0;
    mdl_data  = '0;
    mdl_user  = '0;
    mdl_twrap = '0;
  endtask

  // One clock of stimulus: predict ready, advance the model, check the registered output
  task automatic step(input string tag);
    int          g;
    bit          can;
    logic [N-1:0] exp_rdy;
    longint      sb, sd, s;
    @(negedge clk);
    s_tvalid = tb_valid;
    clr      = tb_clr;
    m_tready = tb_mready;
    for (int i = 0; i < N; i++) s_tdata[i*IW +: IW] = tb_data[i];
    #1;
    can = !mdl_valid || tb_mready;
    g   = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mdl_ptr + k) % N;
        if (g < 0 && tb_valid[c]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk({tag, "_s_tready"}, 64'(s_tready), 64'(exp_rdy));

    for (int i = 0; i < N; i++) begin
      if (i == g) begin
        sb = tb_clr[i] ? 64'sd0 : longint'($signed(mdl_acc[i]));
        sd = longint'($signed(tb_data[i]));
        s  = sb + sd;
        if (tb_clr[i]) mdl_wrap[i] = '0;
        if (s > 64'sd2147483647)        mdl_wrap[i] = mdl_wrap[i] + 16'd1;
        else if (s < -64'sd2147483648)  mdl_wrap[i] = mdl_wrap[i] - 16'd1;
        mdl_acc[i] = s[31:0];
      end else if (tb_clr[i]) begin
        mdl_acc[i]  = '0;
        mdl_wrap[i] = '0;
      end
    end
    if (g >= 0) begin
      mdl_valid = 1'b1;
      mdl_data  = mdl_acc[g];
      mdl_user  = 2'(g);
      mdl_twrap = mdl_wrap[g];
      mdl_ptr   = (g + 1) % N;
    end else if (tb_mready) begin
      mdl_valid = 1'b0;
    end

    @(posedge clk);
    #1;
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(mdl_valid));
    if (mdl_valid) begin
      chk({tag, "_m_tdata"}, 64'(m_tdata), 64'(mdl_data));
      chk({tag, "_m_tuser"}, 64'(m_tuser), 64'(mdl_user));
`ifdef PHASE_WRAP_COUNT_EN
      chk({tag, "_m_twrap"}, 64'(m_twrap), 64'(mdl_twrap));
`endif
    end
  endtask

  // Assert reset (checking the asynchronous effect), hold over an edge, release
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_m_tdata"},  64'(m_tdata),  64'd0);
    chk({tag, "_m_tuser"},  64'(m_tuser),  64'd0);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_s_tready_hold"}, 64'(s_tready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    tb_valid  = '0;
    tb_clr    = '0;
    tb_mready = 1'b1;
    for (int i = 0; i < N; i++) tb_data[i] = $urandom;
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = '1;
    s_tdata  = '0;
    clr      = '0;
    m_tready = 1'b1;
    idle_inputs();
    model_reset();

    // Reset state with every channel requesting
    apply_reset("reset");

    // Single channel accumulation
    idle_inputs();
    tb_valid   = 4'b0001;
    tb_data[0] = 32'h1000_0000;
    for (int n = 0; n < 4; n++) step("single");
    chk("single_final", 64'(m_tdata), 64'h4000_0000);
    idle_inputs();
    step("single_drain");

    // Fairness: all channels requesting from a fresh pointer
    apply_reset("reset_fair");
    idle_inputs();
    tb_valid = 4'b1111;
    for (int i = 0; i < N; i++) tb_data[i] = 32'(i + 1);
    for (int n = 0; n < 8; n++) step("fair");
    chk("fair_last_acc", 64'(m_tdata), 64'd8);

    // Backpressure: five stalled cycles after an accept
    tb_mready = 1'b1;
    for (int i = 0; i < N; i++) tb_data[i] = $urandom;
    step("bp_accept");
    tb_mready = 1'b0;
    for (int n = 0; n < 5; n++) step("bp_stall");
    tb_mready = 1'b1;
    for (int n = 0; n < 4; n++) step("bp_resume");

    // Wrap on channel 1: preload via clear-with-accept, then overflow and return
    idle_inputs();
    tb_valid   = 4'b0010;
    tb_clr     = 4'b0010;
    tb_data[1] = 32'h7FFF_FFF0;
    step("wrap_load");
    tb_clr     = '0;
    tb_data[1] = 32'h0000_0020;
    step("wrap_up");
    chk("wrap_up_data", 64'(m_tdata), 64'h8000_0010);
`ifdef PHASE_WRAP_COUNT_EN
    chk("wrap_up_count", 64'(m_twrap), 64'h0001);
`endif
    tb_data[1] = 32'hFFFF_FFE0;
    step("wrap_down");
    chk("wrap_down_data", 64'(m_tdata), 64'h7FFF_FFF0);
`ifdef PHASE_WRAP_COUNT_EN
    chk("wrap_down_count", 64'(m_twrap), 64'h0000);
`endif

    // Clear colliding with an accept on channel 2
    idle_inputs();
    tb_valid   = 4'b0100;
    tb_clr     = 4'b0100;
    tb_data[2] = 32'h0000_1234;
    step("coll_load");
    tb_clr     = '0;
    tb_data[2] = 32'h0000_0001;
    step("coll_add");
    tb_clr     = 4'b0100;
    tb_data[2] = 32'h0000_0005;
    step("coll_hit");
    chk("coll_result", 64'(m_tdata), 64'h5);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      tb_valid  = 4'($urandom);
      tb_clr    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      tb_mready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        tb_data[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      end
      step("rand");
    end

    // Reset while a result is held
    idle_inputs();
    tb_valid  = 4'b1000;
    tb_mready = 1'b0;
    step("hold_fill");
    step("hold_keep");
    apply_reset("reset_hold");
    idle_inputs();
    tb_valid = 4'b1111;
    step("post_reset");
    chk("post_reset_first_grant", 64'(m_tuser), 64'd0);
    chk("post_reset_acc_zero", 64'(m_tdata), 64'(tb_data[0]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_phase_accum_scheduler
`default_nettype wire
